// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared APB widths and requester state encoding
package apb_pkg;

  localparam int APB_ADDR_WIDTH = 8;
  localparam int APB_DATA_WIDTH = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = ST_IDLE,
    SETUP  = ST_SETUP,
    ACCESS = ST_ACCESS,
    RESP   = ST_RESP
  } apb_state_e;

endpackage

// File: rtl/apb_cmd_master.sv
// rtl/apb_cmd_master.sv - valid/ready command stream to single APB transfers
// One transfer in flight; ACCESS wait is bounded by TIMEOUT_CYCLES (0 disables).
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int ADDR_WIDTH     = APB_ADDR_WIDTH,
  parameter int DATA_WIDTH     = APB_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_slverr,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Abort when the count is about to reach the limit on this stalled cycle
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

  apb_state_e            state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic                  pwrite_q;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [DATA_WIDTH-1:0] pwdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic                  slverr_q;
  logic                  timeout_q;
  logic                  accept;
  logic                  complete;
  logic                  abort;

  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    PSEL      = 1'b0;
    PENABLE   = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    complete  = 1'b0;
    abort     = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = !PRESET;
        if (cmd_valid && !PRESET) begin
          accept  = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        PSEL    = 1'b1;
        state_d = ACCESS;
      end
      ACCESS: begin
        PSEL    = 1'b1;
        PENABLE = 1'b1;
        if (PREADY) begin
          complete = 1'b1;
          state_d  = RESP;
        end else if ((TIMEOUT_CYCLES > 0) && (cnt_q == CNT_LAST)) begin
          abort   = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pwrite_q  <= 1'b0;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      rdata_q   <= '0;
      slverr_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pwrite_q <= cmd_write;
        paddr_q  <= cmd_addr;
        pwdata_q <= cmd_wdata;
        cnt_q    <= '0;
      end else if ((state_q == ACCESS) && !PREADY && (TIMEOUT_CYCLES > 0)) begin
        cnt_q <= cnt_q + 1'b1;
      end
      if (complete) begin
        rdata_q   <= pwrite_q ? '0 : PRDATA;
        slverr_q  <= PSLVERR;
        timeout_q <= 1'b0;
      end else if (abort) begin
        rdata_q   <= '0;
        slverr_q  <= 1'b1;
        timeout_q <= 1'b1;
      end
    end
  end

  // Address/data registers double as the APB bus so they hold between transfers
  assign PWRITE      = pwrite_q;
  assign PADDR       = paddr_q;
  assign PWDATA      = pwdata_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_slverr  = slverr_q;
  assign rsp_timeout = timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// tb/tb_apb_cmd_master.sv - apb_cmd_master against a RAM model with registered PREADY
module tb_apb_cmd_master;

  typedef struct packed {
    logic [31:0] rdata;
    logic        slverr;
    logic        timeout;
  } exp_t;

  logic        PCLK;
  logic        PRESET;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_slverr;
  logic        rsp_timeout;
  logic        PSEL;
  logic        PENABLE;
  logic        PWRITE;
  logic [7:0]  PADDR;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  logic        PSLVERR;

  logic        stall;
  logic        stall_ready;
  logic        ram_ready_q;
  logic [31:0] mem [256];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   rsp_cnt = 0;
  int   apb_done = 0;
  int   last_accept = 0;
  exp_t expq[$];
  exp_t mon_e;

  apb_cmd_master #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .TIMEOUT_CYCLES(16)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  // RAM slave: PREADY registered from PSEL&PENABLE, so it lingers one cycle after PENABLE drops
  initial for (int i = 0; i < 256; i++) mem[i] = 32'h0;
  always @(posedge PCLK) begin
    cyc <= cyc + 1;
    if (PRESET) ram_ready_q <= 1'b0;
    else        ram_ready_q <= PSEL && PENABLE;
    if (PSEL && PENABLE && PREADY) begin
      apb_done <= apb_done + 1;
      if (PWRITE) mem[PADDR] <= PWDATA;
    end
  end
  assign PREADY  = stall ? stall_ready : ram_ready_q;
  assign PRDATA  = mem[PADDR];
  assign PSLVERR = (PADDR == 8'hFF);

  always @(negedge PCLK) begin
    if (!PRESET && rsp_valid && rsp_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("FAIL rsp_unexpected got rdata=%h slverr=%b timeout=%b, no response expected",
                 rsp_rdata, rsp_slverr, rsp_timeout);
      end else begin
        mon_e = expq.pop_front();
        if (rsp_rdata !== mon_e.rdata || rsp_slverr !== mon_e.slverr || rsp_timeout !== mon_e.timeout) begin
          errors++;
          $display("FAIL rsp_data got rdata=%h slverr=%b timeout=%b expected rdata=%h slverr=%b timeout=%b",
                   rsp_rdata, rsp_slverr, rsp_timeout, mon_e.rdata, mon_e.slverr, mon_e.timeout);
        end
      end
      rsp_cnt++;
    end
  end

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  task automatic send_cmd(input logic wr, input logic [7:0] a, input logic [31:0] d,
                          input logic [31:0] er, input logic es, input logic et);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    while (cmd_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL cmd_accept got cmd_ready=%b expected 1 within 200 cycles", cmd_ready);
      cmd_valid = 1'b0;
      return;
    end
    expq.push_back({er, es, et});
    last_accept = cyc;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (expq.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL rsp_wait got %0d pending expected 0 within 200 cycles", expq.size());
    end
  endtask

  task automatic test_reset();
    PRESET    = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 8'h55;
    cmd_wdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({cmd_ready, rsp_valid, rsp_slverr, rsp_timeout, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata} !== '0) begin
        errors++;
        $display("FAIL reset_outputs cycle %0d got cmd_ready=%b rsp_valid=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h rdata=%h expected all 0",
                 k, cmd_ready, rsp_valid, PSEL, PENABLE, PWRITE, PADDR, PWDATA, rsp_rdata);
      end
    end
    cmd_valid = 1'b0;
    PRESET    = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got cmd_ready=%b expected 1", cmd_ready);
    end
  endtask

  task automatic test_write_read();
    rsp_ready = 1'b1;
    checks++;
    if (PSEL !== 1'b0) begin
      errors++;
      $display("FAIL c0_psel got %b expected 0", PSEL);
    end
    send_cmd(1'b1, 8'h10, 32'hDEADBEEF, 32'h0, 1'b0, 1'b0);
    checks++;
    if ({PSEL, PENABLE, PWRITE} !== 3'b101 || PADDR !== 8'h10 || PWDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL c1_setup got sel/en/wr=%b%b%b addr=%h wdata=%h expected 101 10 deadbeef",
               PSEL, PENABLE, PWRITE, PADDR, PWDATA);
    end
    tick();
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL c2_access got sel/en/rspv=%b%b%b expected 110", PSEL, PENABLE, rsp_valid);
    end
    tick();
    checks++;
    if ({PSEL, PENABLE, PREADY, rsp_valid} !== 4'b1110) begin
      errors++;
      $display("FAIL c3_access got sel/en/rdy/rspv=%b%b%b%b expected 1110", PSEL, PENABLE, PREADY, rsp_valid);
    end
    tick();
    checks++;
    if ({rsp_valid, PSEL, PENABLE, cmd_ready} !== 4'b1000) begin
      errors++;
      $display("FAIL c4_resp got rspv/sel/en/cmdr=%b%b%b%b expected 1000", rsp_valid, PSEL, PENABLE, cmd_ready);
    end
    tick();
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0 || PADDR !== 8'h10 || PWRITE !== 1'b1 || PWDATA !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL c5_idle got cmdr=%b rspv=%b addr=%h wr=%b wdata=%h expected 1 0 10 1 deadbeef",
               cmd_ready, rsp_valid, PADDR, PWRITE, PWDATA);
    end
    send_cmd(1'b0, 8'h10, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0);
    wait_idle();
  endtask

  task automatic test_back_to_back();
    int done0 = apb_done;
    int t_prev = 0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_cmd(1'b1, 8'(i), 32'hA5A50000 + 32'(i), 32'h0, 1'b0, 1'b0);
      if (i > 0) begin
        checks++;
        if (last_accept - t_prev != 5) begin
          errors++;
          $display("FAIL b2b_spacing got %0d cycles expected 5", last_accept - t_prev);
        end
      end
      t_prev = last_accept;
    end
    for (int i = 0; i < 4; i++)
      send_cmd(1'b0, 8'(i), 32'h0, 32'hA5A50000 + 32'(i), 1'b0, 1'b0);
    send_cmd(1'b0, 8'hFF, 32'h0, 32'h0, 1'b1, 1'b0);
    wait_idle();
    checks++;
    if (apb_done - done0 != 9) begin
      errors++;
      $display("FAIL b2b_transfers got %0d expected 9", apb_done - done0);
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    rsp_ready = 1'b0;
    send_cmd(1'b0, 8'h01, 32'h0, 32'hA5A50001, 1'b0, 1'b0);
    while (rsp_valid !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_rsp_valid got %b expected 1 within 20 cycles", rsp_valid);
    end
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hA5A50001 || cmd_ready !== 1'b0 || PSEL !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold cycle %0d got rspv=%b rdata=%h cmdr=%b psel=%b expected 1 a5a50001 0 0",
                 k, rsp_valid, rsp_rdata, cmd_ready, PSEL);
      end
      tick();
    end
    rsp_ready = 1'b1;
    wait_idle();
  endtask

  task automatic test_timeout();
    stall       = 1'b1;
    stall_ready = 1'b0;
    rsp_ready   = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) send_cmd(1'b0, 8'h02, 32'h0, 32'h0, 1'b1, 1'b1);
      else           send_cmd(1'b0, 8'h02, 32'h0, 32'hA5A50002, 1'b0, 1'b0);
      for (int k = 1; k <= 16; k++) begin
        tick();
        if (pass == 1 && k == 16) stall_ready = 1'b1;
        checks++;
        if ({PSEL, PENABLE, rsp_valid} !== 3'b110) begin
          errors++;
          $display("FAIL to_access pass %0d cycle %0d got sel/en/rspv=%b%b%b expected 110",
                   pass, k, PSEL, PENABLE, rsp_valid);
        end
      end
      tick();
      stall_ready = 1'b0;
      checks++;
      if (pass == 0 && ({rsp_valid, rsp_timeout, rsp_slverr, PSEL} !== 4'b1110 || rsp_rdata !== 32'h0)) begin
        errors++;
        $display("FAIL to_abort got rspv/to/err/sel=%b%b%b%b rdata=%h expected 1110 00000000",
                 rsp_valid, rsp_timeout, rsp_slverr, PSEL, rsp_rdata);
      end
      if (pass == 1 && ({rsp_valid, rsp_timeout, rsp_slverr, PSEL} !== 4'b1000 || rsp_rdata !== 32'hA5A50002)) begin
        errors++;
        $display("FAIL to_late_ready got rspv/to/err/sel=%b%b%b%b rdata=%h expected 1000 a5a50002",
                 rsp_valid, rsp_timeout, rsp_slverr, PSEL, rsp_rdata);
      end
      rsp_ready = 1'b1;
      wait_idle();
      rsp_ready = 1'b0;
    end
    stall = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    int n = 0;
    int base = rsp_cnt;
    rsp_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 8'h03;
    while (cmd_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    tick();
    cmd_valid = 1'b0;
    tick();
    checks++;
    if ({PSEL, PENABLE} !== 2'b11) begin
      errors++;
      $display("FAIL rst_pre_access got sel/en=%b%b expected 11", PSEL, PENABLE);
    end
    PRESET = 1'b1;
    tick();
    checks++;
    if ({PSEL, PENABLE, rsp_valid} !== 3'b000) begin
      errors++;
      $display("FAIL rst_mid got sel/en/rspv=%b%b%b expected 000", PSEL, PENABLE, rsp_valid);
    end
    PRESET = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    checks++;
    if (rsp_cnt != base) begin
      errors++;
      $display("FAIL rst_dropped got %0d responses expected 0", rsp_cnt - base);
    end
    send_cmd(1'b0, 8'h03, 32'h0, 32'hA5A50003, 1'b0, 1'b0);
    wait_idle();
  endtask

  initial begin
    PRESET      = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_addr    = 8'h0;
    cmd_wdata   = 32'h0;
    rsp_ready   = 1'b0;
    stall       = 1'b0;
    stall_ready = 1'b0;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_timeout();
    test_reset_mid_access();
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d pending expected 0", expq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
